// File: rtl/fxp32_sub_pipe_pkg.sv
// Shared definitions for the fxp32 arithmetic slice: Q16.16 widths, the
// saturation limits and the signed-overflow rule used by the subtractor.
package fxp32_sub_pipe_pkg;

    localparam int FXP32_WIDTH     = 32;
    localparam int FXP32_SEG       = 16;
    localparam int FXP32_FRAC_BITS = 16;

    localparam logic [FXP32_WIDTH-1:0] FXP32_MAX = 32'h7FFF_FFFF;
    localparam logic [FXP32_WIDTH-1:0] FXP32_MIN = 32'h8000_0000;

    // Signed overflow of a - b: the operands have different signs and the
    // result sign differs from the minuend sign.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/fxp32_sub_pipe_seg_add.sv
// One SEG-bit segment adder: sum = a + b + cin with carry-out and an
// msb overflow flag (carry into msb xor carry out of msb). Carries use the
// generate/propagate lookahead recurrence shared with the fxp32 adder.
module fxp_seg_add #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           msb_ovf
);

    logic [SEG-1:0] gen_s;
    logic [SEG-1:0] prop_s;
    logic [SEG:0]   carry_s;

    assign gen_s  = a & b;
    assign prop_s = a ^ b;

    // Carry chain: c[i+1] = g[i] | p[i] & c[i], seeded with cin.
    always_comb begin
        carry_s    = '0;
        carry_s[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            carry_s[i+1] = gen_s[i] | (prop_s[i] & carry_s[i]);
        end
    end

    assign sum     = prop_s ^ carry_s[SEG-1:0];
    assign cout    = carry_s[SEG];
    assign msb_ovf = carry_s[SEG] ^ carry_s[SEG-1];

endmodule

// File: rtl/fxp32_sub_pipe.sv
// Two-stage pipelined Q16.16 subtractor: d = a - b - borrow_in, computed as
// a + ~b + !borrow_in. Stage 1 adds the low segment, stage 2 adds the high
// segment with the stage-1 carry and applies overflow/saturation/borrow.
// Valid/ready on both sides, one operation per cycle when streaming.
module fxp32_sub_pipe
    import fxp32_sub_pipe_pkg::*;
#(
    parameter int WIDTH    = FXP32_WIDTH,
    parameter int SEG      = FXP32_SEG,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_borrow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d,
    output logic             out_overflow,
    output logic             out_borrow
);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Pipeline control
    logic s1_adv_s;
    logic s2_adv_s;
    logic v1_r;
    logic v2_r;

    // Stage 1 payload
    logic [SEG-1:0] s1_lo_sum_r;
    logic           s1_lo_carry_r;
    logic [SEG-1:0] s1_a_hi_r;
    logic [SEG-1:0] s1_nb_hi_r;

    // Stage 1 combinational low-segment add
    logic [SEG-1:0] lo_sum_s;
    logic           lo_cout_s;
    logic           lo_ovf_unused_s;

    // Stage 2 combinational high-segment add and result shaping
    logic [SEG-1:0]   hi_sum_s;
    logic             hi_cout_s;
    logic             hi_ovf_unused_s;
    logic [WIDTH-1:0] raw_s;
    logic             ovf_s;
    logic [WIDTH-1:0] d_next_s;

    // Output registers
    logic [WIDTH-1:0] out_d_r;
    logic             out_overflow_r;
    logic             out_borrow_r;

    // A stage may advance when it is empty or its consumer takes its content.
    assign s2_adv_s = ~v2_r | out_ready;
    assign s1_adv_s = ~v1_r | s2_adv_s;
    assign in_ready = s1_adv_s;

    fxp_seg_add #(
        .SEG (SEG)
    ) u_lo_add (
        .a       (in_a[SEG-1:0]),
        .b       (~in_b[SEG-1:0]),
        .cin     (~in_borrow),
        .sum     (lo_sum_s),
        .cout    (lo_cout_s),
        .msb_ovf (lo_ovf_unused_s)
    );

    fxp_seg_add #(
        .SEG (SEG)
    ) u_hi_add (
        .a       (s1_a_hi_r),
        .b       (s1_nb_hi_r),
        .cin     (s1_lo_carry_r),
        .sum     (hi_sum_s),
        .cout    (hi_cout_s),
        .msb_ovf (hi_ovf_unused_s)
    );

    assign raw_s = {hi_sum_s, s1_lo_sum_r};
    // The subtrahend sign is recovered from its stored complement.
    assign ovf_s = sub_ovf(s1_a_hi_r[SEG-1], ~s1_nb_hi_r[SEG-1], raw_s[WIDTH-1]);

    // Saturation mux: clamp toward the minuend's sign on overflow.
    always_comb begin
        d_next_s = raw_s;
        if ((SATURATE != 0) && ovf_s) begin
            d_next_s = s1_a_hi_r[SEG-1] ? SAT_MIN : SAT_MAX;
        end else begin
            d_next_s = raw_s;
        end
    end

    // Stage 1 register: captures the low-segment sum and the high operand halves on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r          <= 1'b0;
            s1_lo_sum_r   <= '0;
            s1_lo_carry_r <= 1'b0;
            s1_a_hi_r     <= '0;
            s1_nb_hi_r    <= '0;
        end else if (s1_adv_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                s1_lo_sum_r   <= lo_sum_s;
                s1_lo_carry_r <= lo_cout_s;
                s1_a_hi_r     <= in_a[WIDTH-1:SEG];
                s1_nb_hi_r    <= ~in_b[WIDTH-1:SEG];
            end
        end
    end

    // Stage 2 / output register: loads the finished result, holds it while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r           <= 1'b0;
            out_d_r        <= '0;
            out_overflow_r <= 1'b0;
            out_borrow_r   <= 1'b0;
        end else if (s2_adv_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                out_d_r        <= d_next_s;
                out_overflow_r <= ovf_s;
                out_borrow_r   <= ~hi_cout_s;
            end
        end
    end

    assign out_valid    = v2_r;
    assign out_d        = out_d_r;
    assign out_overflow = out_overflow_r;
    assign out_borrow   = out_borrow_r;

endmodule

// File: tb/tb_fxp32_sub_pipe.sv
// Bench for fxp32_sub_pipe: a saturating and a wrapping instance share the
// same stimulus and handshake. Expected results come from a signed-integer
// reference model and are queued on input transfer; a monitor pops and
// compares on every output transfer.
module tb_fxp32_sub_pipe;

    typedef struct {
        logic [31:0] d_sat;
        logic [31:0] d_wrap;
        logic        ovf;
        logic        brw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = 32'h0;
    logic [31:0] in_b = 32'h0;
    logic        in_borrow = 1'b0;
    logic        out_ready;
    logic        rdy_cmd = 1'b1;
    logic        rand_rdy = 1'b0;
    logic        rnd_rdy = 1'b1;

    logic        sat_in_ready, sat_out_valid, sat_ovf, sat_brw;
    logic [31:0] sat_d;
    logic        wrap_in_ready, wrap_out_valid, wrap_ovf, wrap_brw;
    logic [31:0] wrap_d;

    int n_vec = 0;
    int n_fail = 0;
    int n_pop = 0;
    exp_t sb_q[$];

    assign out_ready = rand_rdy ? rnd_rdy : rdy_cmd;

    fxp32_sub_pipe #(.WIDTH(32), .SEG(16), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_a(in_a), .in_b(in_b), .in_borrow(in_borrow),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_d(sat_d),
        .out_overflow(sat_ovf), .out_borrow(sat_brw)
    );

    fxp32_sub_pipe #(.WIDTH(32), .SEG(16), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(wrap_in_ready),
        .in_a(in_a), .in_b(in_b), .in_borrow(in_borrow),
        .out_valid(wrap_out_valid), .out_ready(out_ready), .out_d(wrap_d),
        .out_overflow(wrap_ovf), .out_borrow(wrap_brw)
    );

    always #5 clk = ~clk;

    // Reference: exact signed difference in 64 bits, then clamp or wrap.
    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic bw);
        exp_t   r;
        longint diff;
        longint maxv = 64'sd2147483647;
        longint minv = -64'sd2147483648;
        diff     = longint'($signed(a)) - longint'($signed(b)) - longint'(bw);
        r.ovf    = (diff > maxv) || (diff < minv);
        r.d_wrap = diff[31:0];
        if (r.ovf) r.d_sat = (diff < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else       r.d_sat = diff[31:0];
        r.brw    = longint'({32'h0, a}) < (longint'({32'h0, b}) + longint'(bw));
        return r;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Random output backpressure, active only while rand_rdy is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitor: occupancy/ready rule, stall stability, ordered compare.
    initial begin
        logic        prev_stall = 1'b0;
        logic [31:0] prev_sd = 32'h0, prev_wd = 32'h0;
        logic        prev_o = 1'b0, prev_b = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                chk1("in_ready_rule", sat_in_ready, (sb_q.size() < 2) || out_ready);
                chk1("in_ready_pair", wrap_in_ready, sat_in_ready);
                if (prev_stall) begin
                    chk1("stall_valid", sat_out_valid, 1'b1);
                    chk32("stall_d_sat", sat_d, prev_sd);
                    chk32("stall_d_wrap", wrap_d, prev_wd);
                    chk1("stall_ovf", sat_ovf, prev_o);
                    chk1("stall_brw", sat_brw, prev_b);
                end
                if (sat_out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_output: got d=%h want no result at %0t", sat_d, $time);
                    end else begin
                        e = sb_q.pop_front();
                        n_pop++;
                        chk32("d_sat", sat_d, e.d_sat);
                        chk32("d_wrap", wrap_d, e.d_wrap);
                        chk1("ovf_sat", sat_ovf, e.ovf);
                        chk1("ovf_wrap", wrap_ovf, e.ovf);
                        chk1("brw_sat", sat_brw, e.brw);
                        chk1("brw_wrap", wrap_brw, e.brw);
                        chk1("valid_pair", wrap_out_valid, 1'b1);
                    end
                end
                prev_stall = sat_out_valid && !out_ready;
                prev_sd = sat_d; prev_wd = wrap_d; prev_o = sat_ovf; prev_b = sat_brw;
                if (in_valid && sat_in_ready) begin
                    sb_q.push_back(ref_model(in_a, in_b, in_borrow));
                end
            end
        end
    end

    // Present one operand set and hold it until accepted (bounded).
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bw);
        logic accepted = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_borrow = bw;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sat_in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: got no acceptance want in_ready within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = $urandom(); in_b = $urandom(); in_borrow = 1'($urandom_range(0, 1));
    endtask

    // Single op into an empty pipe with out_ready=1: latency and constant results.
    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic bw, input logic [31:0] e_sat, input logic [31:0] e_wrap,
                            input logic e_ovf, input logic e_brw);
        rdy_cmd = 1'b1;
        send(a, b, bw);
        @(negedge clk);
        chk1({name, "_lat1"}, sat_out_valid, 1'b0);
        @(negedge clk);
        chk1({name, "_lat2"}, sat_out_valid, 1'b1);
        chk32({name, "_dsat"}, sat_d, e_sat);
        chk32({name, "_dwrap"}, wrap_d, e_wrap);
        chk1({name, "_ovf"}, sat_ovf, e_ovf);
        chk1({name, "_ovfw"}, wrap_ovf, e_ovf);
        chk1({name, "_brw"}, sat_brw, e_brw);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 300; t++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d pending want 0", name, sb_q.size());
        end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            5:       return {16'($urandom()), 16'hFFFF};
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int pops0;
        #1000000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0;
        // Reset state
        #2;
        chk1("rst_valid", sat_out_valid, 1'b0);
        chk32("rst_d", sat_d, 32'h0);
        chk1("rst_ovf", sat_ovf, 1'b0);
        chk1("rst_brw", sat_brw, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rst_in_ready", sat_in_ready, 1'b1);
        @(posedge clk);
        #1;

        directed("t1", 32'h0003_0000, 32'h0001_0000, 1'b0, 32'h0002_0000, 32'h0002_0000, 1'b0, 1'b0);
        directed("t2a", 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0);
        directed("t2b", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        directed("t3", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
        directed("t4", 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);

        // Six back-to-back ops with a 3-cycle output stall mid-stream
        pops0 = n_pop;
        fork
            begin
                for (int i = 0; i < 6; i++) send($urandom(), $urandom(), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                rdy_cmd = 1'b0;
                @(negedge clk);
                chk1("t5_full_blocks", sat_in_ready, 1'b0);
                repeat (3) @(posedge clk);
                #1;
                rdy_cmd = 1'b1;
            end
        join
        wait_drain("t5_drain");
        chk32("t5_count", 32'(n_pop - pops0), 32'd6);

        // Asynchronous reset with two ops in flight
        send(32'h0005_0000, 32'h0001_0000, 1'b0);
        send(32'h0009_0000, 32'h0002_0000, 1'b0);
        chk1("t6_pre_valid", sat_out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("t6_valid", sat_out_valid, 1'b0);
        chk32("t6_d", sat_d, 32'h0);
        chk32("t6_dw", wrap_d, 32'h0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        directed("t6_post", 32'h0000_0004, 32'h0000_0006, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0, 1'b1);

        // Randomized ops with random backpressure and idle gaps
        rand_rdy = 1'b1;
        for (int i = 0; i < 10500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
            send(pick_val(), pick_val(), 1'($urandom_range(0, 1)));
        end
        wait_drain("rand_drain");
        rand_rdy = 1'b0;
        rdy_cmd = 1'b1;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
